// File: rtl/temp_supervisor_p.sv
// Temperature supervisor: hysteretic fan/alarm FSM with a persistence filter,
// a latched over-temperature alarm that needs an acknowledge, and a peak register.
module temp_supervisor_p #(
  parameter int TEMP_W      = 5,
  parameter int T_FAN_ON    = 20,
  parameter int T_FAN_OFF   = 17,
  parameter int T_ALARM_ON  = 26,
  parameter int T_ALARM_OFF = 23,
  parameter int PERSIST     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temperatura,
  input  logic              lect,
  input  logic              en_m1,
  input  logic              ack_alarma,
  output logic              est_ventilador,
  output logic              est_alarma,
  output logic [1:0]        estados,
  output logic [TEMP_W-1:0] temp_pico
);

  typedef enum logic [1:0] {
    REPOSO      = 2'b00,
    VENTILACION = 2'b01,
    ALARMA      = 2'b10,
    RETENIDA    = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0]  PERSIST_C    = CNT_W'(PERSIST);
  localparam logic [TEMP_W-1:0] TH_FAN_ON    = TEMP_W'(T_FAN_ON);
  localparam logic [TEMP_W-1:0] TH_FAN_OFF   = TEMP_W'(T_FAN_OFF);
  localparam logic [TEMP_W-1:0] TH_ALARM_ON  = TEMP_W'(T_ALARM_ON);
  localparam logic [TEMP_W-1:0] TH_ALARM_OFF = TEMP_W'(T_ALARM_OFF);
  localparam logic [TEMP_W-1:0] T_SAT        = '1;

  state_t              state, state_nxt;
  state_t              cand_st, cand_st_nxt, cand_now_st;
  logic                cand_vld, cand_vld_nxt, cand_now_vld;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [TEMP_W-1:0]   last_smp, last_nxt, pico_nxt, ack_t;
  logic [2:0]          qual;
  logic                accept, moved;

  // Candidate next state for a sample, {valid, state}; first match wins.
  function automatic logic [2:0] qualify(input state_t st, input logic [TEMP_W-1:0] t);
    logic [2:0] c;
    c = 3'b000;
    case (st)
      REPOSO:      if (t >= TH_ALARM_ON) c = {1'b1, ALARMA};
                   else if (t >= TH_FAN_ON) c = {1'b1, VENTILACION};
      VENTILACION: if (t >= TH_ALARM_ON) c = {1'b1, ALARMA};
                   else if (t <= TH_FAN_OFF) c = {1'b1, REPOSO};
      ALARMA:      if (t <= TH_ALARM_OFF) c = {1'b1, RETENIDA};
      RETENIDA:    if (t >= TH_ALARM_ON) c = {1'b1, ALARMA};
      default:     c = 3'b000;
    endcase
    return c;
  endfunction

  always_comb begin
    accept       = en_m1 & lect;
    qual         = qualify(state, temperatura);
    cand_now_vld = qual[2];
    cand_now_st  = state_t'(qual[1:0]);
    if (!cand_now_vld)
      cnt_inc = '0;
    else if (cand_vld && (cand_st == cand_now_st))
      cnt_inc = cnt + CNT_W'(1);
    else
      cnt_inc = CNT_W'(1);
    // A simultaneous sample is the most recent reading, so ack uses it.
    ack_t = accept ? temperatura : last_smp;

    state_nxt    = state;
    cnt_nxt      = cnt;
    cand_vld_nxt = cand_vld;
    cand_st_nxt  = cand_st;
    last_nxt     = last_smp;
    pico_nxt     = temp_pico;
    moved        = 1'b0;

    if (!en_m1) begin
      cnt_nxt      = '0;
      cand_vld_nxt = 1'b0;
      cand_st_nxt  = REPOSO;
    end else begin
      if (accept) begin
        last_nxt = temperatura;
        if (temperatura > temp_pico)
          pico_nxt = temperatura;
        cnt_nxt      = cnt_inc;
        cand_vld_nxt = cand_now_vld;
        cand_st_nxt  = cand_now_vld ? cand_now_st : REPOSO;
        if ((temperatura == T_SAT) && (state != ALARMA)) begin
          state_nxt = ALARMA;
          moved     = 1'b1;
        end else if (cand_now_vld && (cnt_inc == PERSIST_C)) begin
          state_nxt = cand_now_st;
          moved     = 1'b1;
        end
      end
      // In RETENIDA the only possible sample transition is to ALARMA, which beats ack.
      if ((state == RETENIDA) && ack_alarma && !moved) begin
        state_nxt = (ack_t > TH_FAN_OFF) ? VENTILACION : REPOSO;
        pico_nxt  = ack_t;
        moved     = 1'b1;
      end
      if (moved) begin
        cnt_nxt      = '0;
        cand_vld_nxt = 1'b0;
        cand_st_nxt  = REPOSO;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= REPOSO;
      cnt            <= '0;
      cand_vld       <= 1'b0;
      cand_st        <= REPOSO;
      last_smp       <= '0;
      temp_pico      <= '0;
      est_ventilador <= 1'b0;
      est_alarma     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cand_vld       <= cand_vld_nxt;
      cand_st        <= cand_st_nxt;
      last_smp       <= last_nxt;
      temp_pico      <= pico_nxt;
      est_ventilador <= (state_nxt != REPOSO);
      est_alarma     <= state_nxt[1];
    end
  end

  assign estados = state;

endmodule

// File: tb/tb_temp_supervisor_p.sv
// Directed bench for temp_supervisor_p: stimulus pushes expected state/peak per
// clock into queues, an independent monitor pops and compares on the falling edge.
module tb_temp_supervisor_p;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] temperatura = '0;
  logic       lect = 1'b0;
  logic       en_m1 = 1'b0;
  logic       ack_alarma = 1'b0;
  logic       est_ventilador, est_alarma;
  logic [1:0] estados;
  logic [4:0] temp_pico;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_st_q[$];
  logic [4:0] exp_pk_q[$];
  string      nm_q[$];

  temp_supervisor_p dut (
    .clock(clock), .reset(reset), .temperatura(temperatura), .lect(lect),
    .en_m1(en_m1), .ack_alarma(ack_alarma), .est_ventilador(est_ventilador),
    .est_alarma(est_alarma), .estados(estados), .temp_pico(temp_pico)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got {st,fan,alm,pico}=%b required %b", nm, act, req);
    end
  endtask

  // Expected fan/alarm come straight from the state-code table.
  always @(negedge clock) begin
    if (exp_st_q.size() > 0) begin
      logic [1:0] st;
      logic [4:0] pk;
      string nm;
      st = exp_st_q.pop_front();
      pk = exp_pk_q.pop_front();
      nm = nm_q.pop_front();
      chk(nm, {estados, est_ventilador, est_alarma, temp_pico},
          {st, (st != 2'b00), st[1], pk});
    end
  end

  task automatic step(input logic en, input logic smp, input logic [4:0] t,
                      input logic ack, input logic [1:0] st, input logic [4:0] pk,
                      input string nm);
    en_m1 = en; lect = smp; temperatura = t; ack_alarma = ack;
    @(posedge clock);
    exp_st_q.push_back(st);
    exp_pk_q.push_back(pk);
    nm_q.push_back(nm);
    @(negedge clock);
    lect = 1'b0; ack_alarma = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("reset_state", {estados, est_ventilador, est_alarma, temp_pico}, 9'd0);
    reset = 1'b1;

    step(1, 0, 0, 0, 2'b00, 5'd0, "idle");
    // Three 21s to enter fan mode.
    step(1, 1, 21, 0, 2'b00, 5'd21, "fan_s1");
    step(1, 1, 21, 0, 2'b00, 5'd21, "fan_s2");
    step(1, 1, 21, 0, 2'b01, 5'd21, "fan_s3");
    // 18 breaks the run of 16s.
    step(1, 1, 16, 0, 2'b01, 5'd21, "off_16a");
    step(1, 1, 18, 0, 2'b01, 5'd21, "off_18");
    step(1, 1, 16, 0, 2'b01, 5'd21, "off_16b");
    step(1, 1, 16, 0, 2'b01, 5'd21, "off_16c");
    step(1, 1, 16, 0, 2'b00, 5'd21, "off_16d");
    step(1, 1, 21, 0, 2'b00, 5'd21, "refan1");
    step(1, 1, 21, 0, 2'b00, 5'd21, "refan2");
    step(1, 1, 21, 0, 2'b01, 5'd21, "refan3");
    // Alarm, ignored acks, recovery to latched, ack to fan.
    step(1, 1, 27, 0, 2'b01, 5'd27, "alm1");
    step(1, 1, 27, 0, 2'b01, 5'd27, "alm2");
    step(1, 1, 27, 0, 2'b10, 5'd27, "alm3");
    step(1, 0, 0, 1, 2'b10, 5'd27, "ack_ign1");
    step(1, 0, 0, 1, 2'b10, 5'd27, "ack_ign2");
    step(1, 1, 22, 0, 2'b10, 5'd27, "ret1");
    step(1, 1, 22, 0, 2'b10, 5'd27, "ret2");
    step(1, 1, 22, 0, 2'b11, 5'd27, "ret3");
    step(1, 0, 0, 1, 2'b01, 5'd22, "ack_to_fan");
    // Back to idle, then saturation trip.
    step(1, 1, 16, 0, 2'b01, 5'd22, "cool1");
    step(1, 1, 16, 0, 2'b01, 5'd22, "cool2");
    step(1, 1, 16, 0, 2'b00, 5'd22, "cool3");
    step(1, 1, 31, 0, 2'b10, 5'd31, "sat_trip");
    // Latched; ack coincides with the completing 27 -> alarm wins.
    step(1, 1, 22, 0, 2'b10, 5'd31, "ret_b1");
    step(1, 1, 22, 0, 2'b10, 5'd31, "ret_b2");
    step(1, 1, 22, 0, 2'b11, 5'd31, "ret_b3");
    step(1, 1, 27, 0, 2'b11, 5'd31, "rehot1");
    step(1, 1, 27, 0, 2'b11, 5'd31, "rehot2");
    step(1, 1, 27, 1, 2'b10, 5'd31, "ack_vs_alarm");
    step(1, 1, 15, 0, 2'b10, 5'd31, "ret_c1");
    step(1, 1, 15, 0, 2'b10, 5'd31, "ret_c2");
    step(1, 1, 15, 0, 2'b11, 5'd31, "ret_c3");
    step(1, 0, 0, 1, 2'b00, 5'd15, "ack_to_idle");
    // Boundary 23 releases alarm; ack with a simultaneous 20 uses it.
    step(1, 1, 31, 0, 2'b10, 5'd31, "sat_trip2");
    step(1, 1, 23, 0, 2'b10, 5'd31, "rel23_1");
    step(1, 1, 23, 0, 2'b10, 5'd31, "rel23_2");
    step(1, 1, 23, 0, 2'b11, 5'd31, "rel23_3");
    step(1, 1, 20, 1, 2'b01, 5'd20, "ack_with_smp");
    step(1, 0, 0, 1, 2'b01, 5'd20, "ack_ign_fan");
    // Boundary 17 turns fan off.
    step(1, 1, 17, 0, 2'b01, 5'd20, "off17_1");
    step(1, 1, 17, 0, 2'b01, 5'd20, "off17_2");
    step(1, 1, 17, 0, 2'b00, 5'd20, "off17_3");
    // Disable after two qualifying samples restarts the count.
    step(1, 1, 21, 0, 2'b00, 5'd21, "en_a1");
    step(1, 1, 21, 0, 2'b00, 5'd21, "en_a2");
    step(0, 1, 21, 0, 2'b00, 5'd21, "disabled");
    step(1, 1, 21, 0, 2'b00, 5'd21, "en_b1");
    step(1, 1, 21, 0, 2'b00, 5'd21, "en_b2");
    step(1, 1, 21, 0, 2'b01, 5'd21, "en_b3");

    begin
      int guard = 0;
      while (exp_st_q.size() > 0 && guard < 20) begin
        @(negedge clock);
        guard++;
      end
      if (exp_st_q.size() > 0) begin
        tests++; fails++;
        $display("FAIL drain: %0d expectations left, required 0", exp_st_q.size());
      end
    end

    // Asynchronous reset between edges.
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("async_reset", {estados, est_ventilador, est_alarma, temp_pico}, 9'd0);
    @(negedge clock);
    reset = 1'b1;
    step(1, 0, 0, 0, 2'b00, 5'd0, "post_reset");
    @(negedge clock);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
